// File: rtl/decode_stage.sv
// Instruction-decode stage: drives register-file read addresses, decodes the
// fetched word and holds the result in the ID/EX register with load-use bubbling.
module decode_stage #(
  parameter int DW = 20,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic          id_ready,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic          flush,
  input  logic          ex_stall,
  output logic          ex_valid,
  output logic [3:0]    ex_op,
  output logic [AW-1:0] ex_rd,
  output logic [AW-1:0] ex_rs1,
  output logic [AW-1:0] ex_rs2,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_use_imm,
  output logic          ex_branch,
  output logic          ex_jump,
  output logic          ex_illegal,
  output logic [CW-1:0] stall_count
);

  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpAddi = 4'd5;
  localparam logic [3:0] OpLd   = 4'd6;
  localparam logic [3:0] OpSt   = 4'd7;
  localparam logic [3:0] OpBeq  = 4'd8;
  localparam logic [3:0] OpJ    = 4'd9;

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic          regWrite;
    logic          memRead;
    logic          memWrite;
    logic          useImm;
    logic          branch;
    logic          jump;
    logic          illegal;
  } idEx_t;

  idEx_t exReg;
  idEx_t decoded;
  logic [3:0] op;
  logic storeOrBranch;
  logic usesRs1;
  logic usesRs2;
  logic hazard;

  assign op            = if_instr[19:16];
  assign storeOrBranch = (op == OpSt) || (op == OpBeq);
  assign rf_raddr1     = if_instr[11:8];
  assign rf_raddr2     = storeOrBranch ? if_instr[15:12] : if_instr[7:4];
  assign usesRs1       = (op >= OpAdd) && (op <= OpBeq);
  assign usesRs2       = ((op >= OpAdd) && (op <= OpOr)) || storeOrBranch;

  // A load still in ID/EX cannot forward in time to a consumer sitting in ID.
  assign hazard = exReg.valid && exReg.memRead && if_valid &&
                  ((usesRs1 && (exReg.rd == rf_raddr1)) ||
                   (usesRs2 && (exReg.rd == rf_raddr2)));

  // Handshake: IF's word is consumed on a posedge where if_valid && id_ready;
  // under flush id_ready is high but the word is dropped rather than captured.
  assign id_ready = !reset && (flush || (!ex_stall && !hazard));

  always_comb begin
    decoded       = '0;
    decoded.valid = 1'b1;
    decoded.op    = op;
    decoded.rs1   = rf_raddr1;
    decoded.rs2   = rf_raddr2;
    decoded.rd    = storeOrBranch ? '0 : if_instr[15:12];
    decoded.a     = rf_data1;
    decoded.b     = rf_data2;
    decoded.pc    = if_pc;
    decoded.imm   = (op == OpJ) ? {{(DW-12){if_instr[11]}}, if_instr[11:0]}
                                : {{(DW-8){if_instr[7]}}, if_instr[7:0]};
    case (op)
      4'd0: ;
      4'd1, 4'd2, 4'd3, 4'd4: decoded.regWrite = 1'b1;
      OpAddi: begin
        decoded.regWrite = 1'b1;
        decoded.useImm   = 1'b1;
      end
      OpLd: begin
        decoded.regWrite = 1'b1;
        decoded.memRead  = 1'b1;
        decoded.useImm   = 1'b1;
      end
      OpSt: begin
        decoded.memWrite = 1'b1;
        decoded.useImm   = 1'b1;
      end
      OpBeq:   decoded.branch  = 1'b1;
      OpJ:     decoded.jump    = 1'b1;
      default: decoded.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      exReg       <= '0;
      stall_count <= '0;
    end else if (flush) begin
      exReg <= '0;
    end else if (ex_stall) begin
      exReg <= exReg;
    end else if (hazard) begin
      exReg <= '0;
      if (stall_count != '1) stall_count <= stall_count + 1'b1;
    end else if (if_valid) begin
      exReg <= decoded;
    end else begin
      exReg <= '0;
    end
  end

  assign ex_valid     = exReg.valid;
  assign ex_op        = exReg.op;
  assign ex_rd        = exReg.rd;
  assign ex_rs1       = exReg.rs1;
  assign ex_rs2       = exReg.rs2;
  assign ex_a         = exReg.a;
  assign ex_b         = exReg.b;
  assign ex_imm       = exReg.imm;
  assign ex_pc        = exReg.pc;
  assign ex_reg_write = exReg.regWrite;
  assign ex_mem_read  = exReg.memRead;
  assign ex_mem_write = exReg.memWrite;
  assign ex_use_imm   = exReg.useImm;
  assign ex_branch    = exReg.branch;
  assign ex_jump      = exReg.jump;
  assign ex_illegal   = exReg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued as each
// instruction is driven and compared after the following posedge.
module tb_decode_stage;

  localparam int K_ACC  = 0;  // instruction captured
  localparam int K_BUB  = 1;  // bubble, no stall counted
  localparam int K_HAZ  = 2;  // load-use bubble, counted
  localparam int K_HOLD = 3;  // EX back-pressure, ID/EX unchanged

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [19:0] a;
    logic [19:0] b;
    logic [19:0] imm;
    logic [19:0] pc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ui;
    logic        br;
    logic        jp;
    logic        il;
  } ex_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [19:0] if_instr = '0;
  logic [19:0] if_pc = '0;
  logic        id_ready;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [19:0] rf_data1 = '0;
  logic [19:0] rf_data2 = '0;
  logic        flush = 1'b0;
  logic        ex_stall = 1'b0;
  logic        ex_valid;
  logic [3:0]  ex_op, ex_rd, ex_rs1, ex_rs2;
  logic [19:0] ex_a, ex_b, ex_imm, ex_pc;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm;
  logic        ex_branch, ex_jump, ex_illegal;
  logic [15:0] stall_count;

  int n_assert = 0;
  int n_fail = 0;
  int exp_stalls = 0;
  ex_t exp_q[$];
  ex_t mask_q[$];
  ex_t last_exp = '0;
  ex_t last_mask = '1;

  decode_stage dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_use_imm(ex_use_imm), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t observed();
    return {ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, ex_a, ex_b, ex_imm, ex_pc,
            ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm, ex_branch,
            ex_jump, ex_illegal};
  endfunction

  function automatic ex_t model(input logic [19:0] instr, pc, d1, d2);
    ex_t m;
    logic [3:0] o;
    logic stb;
    o = instr[19:16];
    stb = (o == 4'd7) || (o == 4'd8);
    m = '0;
    m.valid = 1'b1;
    m.op  = o;
    m.rs1 = instr[11:8];
    m.rs2 = stb ? instr[15:12] : instr[7:4];
    m.rd  = stb ? 4'd0 : instr[15:12];
    m.a   = d1;
    m.b   = d2;
    m.pc  = pc;
    m.imm = (o == 4'd9) ? {{8{instr[11]}}, instr[11:0]} : {{12{instr[7]}}, instr[7:0]};
    case (o)
      4'd1, 4'd2, 4'd3, 4'd4: m.rw = 1'b1;
      4'd5: begin m.rw = 1'b1; m.ui = 1'b1; end
      4'd6: begin m.rw = 1'b1; m.mr = 1'b1; m.ui = 1'b1; end
      4'd7: begin m.mw = 1'b1; m.ui = 1'b1; end
      4'd8: m.br = 1'b1;
      4'd9: m.jp = 1'b1;
      4'd0: ;
      default: m.il = 1'b1;
    endcase
    return m;
  endfunction

  // Bubbles only promise ex_valid and the control bits are clear.
  function automatic ex_t bubble_mask();
    ex_t m;
    m = '0;
    m.valid = 1'b1;
    {m.rw, m.mr, m.mw, m.ui, m.br, m.jp, m.il} = '1;
    return m;
  endfunction

  task automatic step(input logic v, input logic [19:0] instr, pc, d1, d2,
                      input logic st, fl, input int kind);
    ex_t e, m, got;
    logic [3:0] o;
    if_valid = v; if_instr = instr; if_pc = pc;
    rf_data1 = d1; rf_data2 = d2; ex_stall = st; flush = fl;
    case (kind)
      K_ACC:   begin e = model(instr, pc, d1, d2); m = '1; end
      K_HOLD:  begin e = last_exp; m = last_mask; end
      default: begin e = '0; m = bubble_mask(); end
    endcase
    if (kind == K_HAZ) exp_stalls++;
    exp_q.push_back(e);
    mask_q.push_back(m);
    last_exp = e;
    last_mask = m;
    o = instr[19:16];
    @(negedge clock);
    chk("id_ready", id_ready, (kind == K_ACC) || (kind == K_BUB));
    chk("rf_raddr1", rf_raddr1, instr[11:8]);
    chk("rf_raddr2", rf_raddr2, ((o == 4'd7) || (o == 4'd8)) ? instr[15:12] : instr[7:4]);
    @(posedge clock);
    #1;
    got = observed();
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    chk("id_ex", got & m, e & m);
    chk("stall_count", stall_count, exp_stalls);
  endtask

  initial begin
    logic [19:0] rnd;
    // Reset held two cycles with IF presenting work
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1; if_valid = 1'b1; if_instr = 20'h13120;
      @(negedge clock);
      chk("reset_id_ready", id_ready, 1'b0);
      @(posedge clock);
      #1;
      chk("reset_ex", observed(), '0);
      chk("reset_stall_count", stall_count, 0);
    end
    reset = 1'b0;

    step(1, 20'h13120, 20'h00010, 20'd5, 20'd7, 0, 0, K_ACC);
    chk("add_op", ex_op, 4'd1);
    chk("add_rd", ex_rd, 4'd3);
    chk("add_a", ex_a, 20'd5);
    chk("add_b", ex_b, 20'd7);
    chk("add_rw", ex_reg_write, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rnd = {4'($urandom_range(1, 5)), 16'($urandom_range(0, 65535))};
      step(1, rnd, 20'($urandom_range(0, 1048575)), 20'($urandom_range(0, 1048575)),
           20'($urandom_range(0, 1048575)), 0, 0, K_ACC);
    end

    step(1, 20'h54180, 20'h00020, 20'd1, 20'd2, 0, 0, K_ACC);
    chk("addi_imm", ex_imm, 20'hFFF80);
    chk("addi_use_imm", ex_use_imm, 1'b1);
    step(1, 20'h90800, 20'h00024, 20'd3, 20'd4, 0, 0, K_ACC);
    chk("j_imm", ex_imm, 20'hFF800);
    chk("j_jump", ex_jump, 1'b1);
    step(1, 20'hF1234, 20'h00028, 20'd0, 20'd0, 0, 0, K_ACC);
    chk("illegal_flag", ex_illegal, 1'b1);
    chk("illegal_valid", ex_valid, 1'b1);

    // Load-use on rs1, then the consumer issues
    step(1, 20'h62104, 20'h00030, 20'd9, 20'd1, 0, 0, K_ACC);
    step(1, 20'h15210, 20'h00034, 20'd2, 20'd3, 0, 0, K_HAZ);
    chk("lu_bubble", ex_valid, 1'b0);
    step(1, 20'h15210, 20'h00034, 20'd2, 20'd3, 0, 0, K_ACC);
    step(1, 20'h62104, 20'h00038, 20'd9, 20'd1, 0, 0, K_ACC);
    step(1, 20'h15160, 20'h0003C, 20'd4, 20'd6, 0, 0, K_ACC);

    // Store data register collides with load destination
    step(1, 20'h67100, 20'h00040, 20'd1, 20'd0, 0, 0, K_ACC);
    step(1, 20'h77104, 20'h00044, 20'd1, 20'd7, 0, 0, K_HAZ);
    step(1, 20'h77104, 20'h00044, 20'd1, 20'd7, 0, 0, K_ACC);
    chk("st_rs2", ex_rs2, 4'd7);
    chk("st_mem_write", ex_mem_write, 1'b1);
    chk("st_rd", ex_rd, 4'd0);

    // Back-pressure over a pending hazard holds and does not count
    step(1, 20'h61100, 20'h00050, 20'd8, 20'd0, 0, 0, K_ACC);
    for (int i = 0; i < 3; i++)
      step(1, 20'h13120, 20'h00054, 20'd5, 20'd7, 1, 0, K_HOLD);
    chk("stall_hold_pc", ex_pc, 20'h00050);
    step(1, 20'h13120, 20'h00054, 20'd5, 20'd7, 0, 0, K_HAZ);
    step(1, 20'h13120, 20'h00054, 20'd5, 20'd7, 0, 0, K_ACC);

    // Flush wins over stall; flush also suppresses a hazard count
    step(1, 20'h22340, 20'h00060, 20'd1, 20'd1, 1, 1, K_BUB);
    step(0, 20'h22340, 20'h00060, 20'd1, 20'd1, 0, 0, K_BUB);
    step(1, 20'h62104, 20'h00070, 20'd9, 20'd1, 0, 0, K_ACC);
    step(1, 20'h15210, 20'h00074, 20'd2, 20'd3, 0, 1, K_BUB);
    step(1, 20'h15210, 20'h00074, 20'd2, 20'd3, 0, 0, K_ACC);
    step(0, 20'h00000, 20'h00078, 20'd0, 20'd0, 0, 0, K_BUB);
    chk("final_stall_count", stall_count, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction-decode stage of the 20-bit pipelined processor, directly upstream of the 16x20 register file.
- Takes fetched instructions from IF and drives the register-file read addresses combinationally.
- Captures the returned operands, decodes control and immediates, and holds them in the ID/EX pipeline register.
- Detects load-use hazards (inserts one bubble), honours EX back-pressure and branch flush, and counts stall cycles.

Parameters:
DW, 20, data/instruction/PC width
AW, 4, register address width (16 registers, all writable; r0 not hard-wired)
CW, 16, stall counter width

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high
if_valid  in  1  IF presents an instruction
if_instr  in  DW  instruction word
if_pc  in  DW  PC of if_instr
id_ready  out  1  decode accepts if_instr this cycle
rf_raddr1  out  AW  register-file read address 1 (combinational)
rf_raddr2  out  AW  register-file read address 2 (combinational)
rf_data1  in  DW  register-file read data 1
rf_data2  in  DW  register-file read data 2
flush  in  1  taken branch/jump resolved in EX; kill ID and ID/EX
ex_stall  in  1  EX cannot accept; hold ID/EX
ex_valid  out  1  ID/EX holds a real instruction
ex_op  out  4  opcode
ex_rd, ex_rs1, ex_rs2  out  AW each  destination / source register indices
ex_a, ex_b  out  DW each  operands (rf_data1, rf_data2)
ex_imm  out  DW  sign-extended immediate
ex_pc  out  DW  PC
ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm, ex_branch, ex_jump, ex_illegal  out  1 each  control
stall_count  out  CW  saturating count of load-use bubble cycles

Behaviour:
- Fields: op=[19:16], rd=[15:12], rs1=[11:8], rs2=[7:4], imm8=[7:0], imm12=[11:0].
- rf_raddr1=[11:8] always.
- rf_raddr2=[15:12] for ST/BEQ, otherwise [7:4].
- Opcodes and controls:
  - 0 NOP: all controls 0.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: reg_write; use rs1 and rs2.
  - 5 ADDI: reg_write, use_imm; uses rs1.
  - 6 LD: reg_write, mem_read, use_imm; uses rs1.
  - 7 ST: mem_write, use_imm; uses rs1 (base) and [15:12] (data).
  - 8 BEQ: branch; uses [11:8] and [15:12].
  - 9 J: jump; no sources.
  - 10-15: ex_illegal=1, all other controls 0, ex_valid=1.
- For ST/BEQ, ex_rs2=[15:12] and ex_rd=0.
- Immediate: ex_imm = sign-extend imm8 to 20 bits; for J, sign-extend imm12. imm8=0x80 gives 0xFFF80; imm12=0x800 gives 0xFF800.
- Register-file writes land on the negedge before the posedge capture, so same-cycle WB data is already visible. No WB bypass exists in this stage.
- Hazard condition: ex_valid & ex_mem_read & (ex_rd equals a source register actually used by if_instr) & if_valid.
- Update priority each posedge: reset > flush > ex_stall > hazard > normal.
  - reset: ex_valid=0, all ex_* outputs=0, stall_count=0. id_ready=0 during reset.
  - flush: ex_valid=0, ex_* controls=0. id_ready=1, but the current if_instr is discarded, not captured. flush has priority over ex_stall.
  - ex_stall (no flush): ID/EX holds all values; id_ready=0. No hazard bubble counted.
  - hazard: ID/EX loads a bubble (ex_valid=0, controls=0); id_ready=0; stall_count+1, saturating at 2^CW-1. Exactly one bubble per LD, since the next cycle EX holds the bubble.
  - normal: if if_valid, capture decode plus rf_data into ID/EX with ex_valid=1, else load a bubble. id_ready=1.
- id_ready is combinational: !reset & (flush | (!ex_stall & !hazard)).
- Latency: an accepted instruction appears on ex_* the next posedge.

Test Plan:
- Reset: assert reset 2 cycles with if_valid=1 -> ex_valid=0, all ex_*=0, stall_count=0, id_ready=0; first instruction after release appears 1 cycle later.
- ADD r3,r1,r2 (0x13120) with rf_data1=5, rf_data2=7 -> next posedge: ex_op=1, ex_rd=3, ex_a=5, ex_b=7, ex_reg_write=1, rf_raddr1=1, rf_raddr2=2.
- ADDI r4,r1,-128 (0x54180) -> ex_imm=0xFFF80, ex_use_imm=1; J imm12=0x800 (0x90800) -> ex_imm=0xFF800, ex_jump=1; opcode 0xF -> ex_illegal=1, ex_valid=1.
- LD r2 followed by ADD r5,r2,r1 -> one bubble (ex_valid=0), id_ready=0 for 1 cycle, stall_count=1, then ADD issues. Repeat with ADD r5,r1,r6 -> no bubble.
- ST r7,[r1+4] (0x77104) -> rf_raddr2=7, ex_rs2=7, ex_mem_write=1, ex_rd=0. Preceded by LD r7 -> hazard bubble.
- ex_stall=1 for 3 cycles -> ex_* stable, id_ready=0, stall_count unchanged. flush together with ex_stall -> ex_valid=0 next cycle, instruction dropped.
